// File: rtl/core_pkg.sv
// Shared core definitions: ID opcodes, PC-source and sequencing-state encodings,
// and the bundle of pipeline-register controls produced by the hazard controller.
package core_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [1:0] PC_SEQ   = 2'b00;
  localparam logic [1:0] PC_JUMP  = 2'b01;
  localparam logic [1:0] PC_REDIR = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_HALT     = 2'b10
  } ctrl_state_t;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ifid_write;
    logic       idex_write;
    logic       exmem_write;
    logic       memwb_write;
    logic       ifid_flush;
    logic       idex_flush;
  } pipe_ctrl_t;

  // Everything held, nothing bubbled: used for reset, freeze and halt.
  localparam pipe_ctrl_t CTRL_IDLE = '{
    pc_write: 1'b0, pc_src: PC_SEQ, ifid_write: 1'b0, idex_write: 1'b0,
    exmem_write: 1'b0, memwb_write: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b0};

  localparam pipe_ctrl_t CTRL_RUN = '{
    pc_write: 1'b1, pc_src: PC_SEQ, ifid_write: 1'b1, idex_write: 1'b1,
    exmem_write: 1'b1, memwb_write: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0};

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bus: pipeline status in, register enables / flushes / PC mux out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             id_jump;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_redirect;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             ifid_write;
  logic             idex_write;
  logic             exmem_write;
  logic             memwb_write;
  logic             ifid_flush;
  logic             idex_flush;
  logic             mem_timeout;
  logic [1:0]       ctrl_state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_jump,
           ex_rd, ex_mem_read, ex_redirect, mem_req, mem_ready,
    input  pc_write, pc_src, ifid_write, idex_write, exmem_write, memwb_write,
           ifid_flush, idex_flush, mem_timeout, ctrl_state, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_jump,
           ex_rd, ex_mem_read, ex_redirect, mem_req, mem_ready,
    output pc_write, pc_src, ifid_write, idex_write, exmem_write, memwb_write,
           ifid_flush, idex_flush, mem_timeout, ctrl_state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_sat_counter.sv
// Saturating event counter: clears synchronously, sticks at all-ones.
module hazard_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);
  logic [CNT_W-1:0] r_count;

  // count register: clear wins, then increment unless already saturated
  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_count <= {CNT_W{1'b0}};
    end else if (i_inc && !(&r_count)) begin
      r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, ID jumps, EX redirects and
// data-memory freeze with a timeout watchdog and stall/flush counters.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8,
  parameter int CNT_W       = 32
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  bus
);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);
  localparam logic [TO_W-1:0] WAIT_ONE = {{(TO_W-1){1'b0}}, 1'b1};

  ctrl_state_t     r_state;
  ctrl_state_t     w_state_nxt;
  logic [TO_W-1:0] r_wait_cnt;
  logic [TO_W-1:0] w_wait_nxt;
  logic            r_timeout;
  logic            w_timeout_nxt;
  logic            w_freeze;
  logic            w_load_use;
  logic            w_flush_evt;
  pipe_ctrl_t      w_ctrl;

  assign w_load_use = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                      ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                       (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

  // freeze: memory still busy; HALT counts as permanently frozen
  always_comb begin
    w_freeze = 1'b1;
    case (r_state)
      ST_RUN:      w_freeze = bus.mem_req && !bus.mem_ready;
      ST_MEM_WAIT: w_freeze = !bus.mem_ready;
      ST_HALT:     w_freeze = 1'b1;
      default:     w_freeze = 1'b1;
    endcase
  end

  // state register with wait counter and sticky watchdog flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= {TO_W{1'b0}};
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  // next state: the wait counter is zero in RUN, so +1 also seeds the first wait cycle
  always_comb begin
    w_state_nxt   = r_state;
    w_wait_nxt    = r_wait_cnt;
    w_timeout_nxt = r_timeout;
    case (r_state)
      ST_RUN, ST_MEM_WAIT: begin
        if (w_freeze) begin
          w_wait_nxt = r_wait_cnt + WAIT_ONE;
          if (w_wait_nxt >= TO_LIMIT) begin
            w_state_nxt   = ST_HALT;
            w_timeout_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_MEM_WAIT;
          end
        end else begin
          w_state_nxt = ST_RUN;
          w_wait_nxt  = {TO_W{1'b0}};
        end
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_wait_nxt  = {TO_W{1'b0}};
      end
    endcase
  end

  // outputs: redirect beats load-use, load-use beats a jump in the same cycle
  always_comb begin
    w_ctrl      = CTRL_IDLE;
    w_flush_evt = 1'b0;
    if (reset || w_freeze) begin
      w_ctrl = CTRL_IDLE;
    end else begin
      w_ctrl = CTRL_RUN;
      if (bus.ex_redirect) begin
        w_ctrl.pc_src     = PC_REDIR;
        w_ctrl.ifid_flush = 1'b1;
        w_ctrl.idex_flush = 1'b1;
        w_flush_evt       = 1'b1;
      end else if (w_load_use) begin
        w_ctrl.pc_write   = 1'b0;
        w_ctrl.ifid_write = 1'b0;
        w_ctrl.idex_flush = 1'b1;
      end else if (bus.id_jump) begin
        w_ctrl.pc_src     = PC_JUMP;
        w_ctrl.ifid_flush = 1'b1;
        w_flush_evt       = 1'b1;
      end else begin
        w_ctrl = CTRL_RUN;
      end
    end
  end

  assign bus.pc_write    = w_ctrl.pc_write;
  assign bus.pc_src      = w_ctrl.pc_src;
  assign bus.ifid_write  = w_ctrl.ifid_write;
  assign bus.idex_write  = w_ctrl.idex_write;
  assign bus.exmem_write = w_ctrl.exmem_write;
  assign bus.memwb_write = w_ctrl.memwb_write;
  assign bus.ifid_flush  = w_ctrl.ifid_flush;
  assign bus.idex_flush  = w_ctrl.idex_flush;
  assign bus.ctrl_state  = r_state;
  assign bus.mem_timeout = r_timeout;

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .i_clear (reset),
    .i_inc   (!w_ctrl.pc_write),
    .o_count (bus.stall_cnt)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .i_clear (reset),
    .i_inc   (w_flush_evt),
    .o_count (bus.flush_cnt)
  );
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios then random traffic, checked against a
// rule-level model; a second instance with 3-bit counters covers saturation.
module tb_hazard_ctrl;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [4:0] s_rs1, s_rs2, s_rd;
  logic s_use1, s_use2, s_jump, s_mrd, s_redir, s_req, s_rdy;

  hazard_ctrl_if #(.CNT_W(32)) bus_a ();
  hazard_ctrl_if #(.CNT_W(3))  bus_b ();

  assign bus_a.id_rs1 = s_rs1;      assign bus_b.id_rs1 = s_rs1;
  assign bus_a.id_rs2 = s_rs2;      assign bus_b.id_rs2 = s_rs2;
  assign bus_a.id_use_rs1 = s_use1; assign bus_b.id_use_rs1 = s_use1;
  assign bus_a.id_use_rs2 = s_use2; assign bus_b.id_use_rs2 = s_use2;
  assign bus_a.id_jump = s_jump;    assign bus_b.id_jump = s_jump;
  assign bus_a.ex_rd = s_rd;        assign bus_b.ex_rd = s_rd;
  assign bus_a.ex_mem_read = s_mrd; assign bus_b.ex_mem_read = s_mrd;
  assign bus_a.ex_redirect = s_redir; assign bus_b.ex_redirect = s_redir;
  assign bus_a.mem_req = s_req;     assign bus_b.mem_req = s_req;
  assign bus_a.mem_ready = s_rdy;   assign bus_b.mem_ready = s_rdy;

  hazard_ctrl #(.MEM_TIMEOUT(TO), .TO_W(8), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .bus(bus_a));
  hazard_ctrl #(.MEM_TIMEOUT(TO), .TO_W(8), .CNT_W(3)) u_sat (
    .clk(clk), .reset(reset), .bus(bus_b));

  int n_cmp = 0;
  int n_err = 0;

  // model: mode 0 = running, 1 = waiting on memory, 2 = halted
  int     m_mode = 0;
  int     m_wait = 0;
  logic   m_to = 1'b0;
  longint m_stall = 0;
  longint m_flush = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] obs_ctrl_a();
    return {bus_a.pc_write, bus_a.pc_src, bus_a.ifid_write, bus_a.idex_write,
            bus_a.exmem_write, bus_a.memwb_write, bus_a.ifid_flush, bus_a.idex_flush};
  endfunction

  function automatic logic [8:0] obs_ctrl_b();
    return {bus_b.pc_write, bus_b.pc_src, bus_b.ifid_write, bus_b.idex_write,
            bus_b.exmem_write, bus_b.memwb_write, bus_b.ifid_flush, bus_b.idex_flush};
  endfunction

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  // one cycle: compare against the model, then let the clock edge advance both
  task automatic step(input string tag);
    logic       frozen, lu, pw, evt;
    logic [1:0] src, fl;
    logic [3:0] en;
    #1;
    frozen = (m_mode == 2) || (m_mode == 0 && s_req && !s_rdy) || (m_mode == 1 && !s_rdy);
    lu = s_mrd && (s_rd != 5'd0) && ((s_use1 && s_rs1 == s_rd) || (s_use2 && s_rs2 == s_rd));
    pw = 1'b0; src = 2'd0; en = 4'b0000; fl = 2'b00; evt = 1'b0;
    if (!reset && !frozen) begin
      pw = 1'b1; en = 4'b1111;
      if (s_redir) begin
        src = 2'd2; fl = 2'b11; evt = 1'b1;
      end else if (lu) begin
        pw = 1'b0; en = 4'b0111; fl = 2'b01;
      end else if (s_jump) begin
        src = 2'd1; fl = 2'b10; evt = 1'b1;
      end
    end
    chk({tag, ":ctrl"}, 64'(obs_ctrl_a()), 64'({pw, src, en, fl}));
    chk({tag, ":ctrl_b"}, 64'(obs_ctrl_b()), 64'({pw, src, en, fl}));
    chk({tag, ":state"}, 64'({bus_a.mem_timeout, bus_a.ctrl_state}), 64'({m_to, 2'(m_mode)}));
    chk({tag, ":stall"}, 64'(bus_a.stall_cnt), 64'(m_stall));
    chk({tag, ":flush"}, 64'(bus_a.flush_cnt), 64'(m_flush));
    chk({tag, ":stall_b"}, 64'(bus_b.stall_cnt), 64'(sat(m_stall, 7)));
    chk({tag, ":flush_b"}, 64'(bus_b.flush_cnt), 64'(sat(m_flush, 7)));
    @(posedge clk);
    if (reset) begin
      m_mode = 0; m_wait = 0; m_to = 1'b0; m_stall = 0; m_flush = 0;
    end else begin
      if (!pw) m_stall++;
      if (evt) m_flush++;
      if (m_mode != 2) begin
        if (frozen) begin
          m_wait++;
          if (m_wait >= TO) begin m_mode = 2; m_to = 1'b1; end
          else m_mode = 1;
        end else begin
          m_mode = 0; m_wait = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_in();
    s_rs1 = 5'd0; s_rs2 = 5'd0; s_rd = 5'd0; s_use1 = 1'b0; s_use2 = 1'b0;
    s_jump = 1'b0; s_mrd = 1'b0; s_redir = 1'b0; s_req = 1'b0; s_rdy = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1; idle_in();
    step("rst");
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; idle_in();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 chk("reset_ctrl", 64'(obs_ctrl_a()), 64'd0);
    step("reset");
    reset = 1'b0;

    // load-use on rs1, then ex_rd = 0 must not stall
    s_mrd = 1'b1; s_rd = 5'd5; s_rs1 = 5'd5; s_use1 = 1'b1;
    step("lu");
    s_mrd = 1'b0;
    step("lu_after");
    chk("lu_stall_cnt", 64'(bus_a.stall_cnt), 64'd1);
    s_mrd = 1'b1; s_rd = 5'd0; s_rs1 = 5'd0;
    step("lu_x0");
    chk("x0_stall_cnt", 64'(bus_a.stall_cnt), 64'd1);

    // redirect beats jump and load-use
    do_reset();
    s_redir = 1'b1; s_jump = 1'b1; s_mrd = 1'b1; s_rd = 5'd7; s_rs2 = 5'd7; s_use2 = 1'b1;
    #1 chk("redir_pc_src", 64'(bus_a.pc_src), 64'd2);
    step("redir");
    idle_in();
    step("redir_after");
    chk("redir_flush_cnt", 64'(bus_a.flush_cnt), 64'd1);

    // jump with load-use: stall first, jump next cycle
    s_jump = 1'b1; s_mrd = 1'b1; s_rd = 5'd3; s_rs1 = 5'd3; s_use1 = 1'b1;
    #1 chk("jlu_pc_src", 64'(bus_a.pc_src), 64'd0);
    step("jlu1");
    s_mrd = 1'b0;
    #1 chk("jlu_jump", 64'({bus_a.pc_src, bus_a.ifid_flush}), 64'({2'd1, 1'b1}));
    step("jlu2");
    idle_in();

    // three frozen cycles then release
    do_reset();
    s_req = 1'b1; s_rdy = 1'b0; s_redir = 1'b1;
    repeat (3) step("mwait");
    s_rdy = 1'b1; s_redir = 1'b0;
    #1 chk("mw_state", 64'(bus_a.ctrl_state), 64'd1);
    chk("mw_release", 64'(obs_ctrl_a()), 64'(9'b1_00_1111_00));
    step("mw_rel");
    chk("mw_stall_cnt", 64'(bus_a.stall_cnt), 64'd3);

    // watchdog
    do_reset();
    s_req = 1'b1; s_rdy = 1'b0;
    repeat (TO) step("to");
    chk("to_state", 64'({bus_a.mem_timeout, bus_a.ctrl_state}), 64'({1'b1, 2'd2}));
    s_rdy = 1'b1;
    repeat (2) step("halt");
    chk("halt_sticky", 64'({bus_a.mem_timeout, bus_a.ctrl_state}), 64'({1'b1, 2'd2}));
    do_reset();
    chk("to_cleared", 64'({bus_a.mem_timeout, bus_a.ctrl_state}), 64'd0);

    // saturation on the 3-bit instance
    s_mrd = 1'b1; s_rd = 5'd9; s_rs2 = 5'd9; s_use2 = 1'b1;
    repeat (10) step("sat");
    chk("sat_stall_cnt", 64'(bus_b.stall_cnt), 64'd7);
    repeat (2) step("sat_hold");
    chk("sat_stall_hold", 64'(bus_b.stall_cnt), 64'd7);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      reset   = ($urandom_range(0, 49) == 0);
      s_rs1   = 5'($urandom_range(0, 3));
      s_rs2   = 5'($urandom_range(0, 3));
      s_rd    = 5'($urandom_range(0, 3));
      s_use1  = 1'($urandom);
      s_use2  = 1'($urandom);
      s_jump  = ($urandom_range(0, 3) == 0);
      s_mrd   = 1'($urandom);
      s_redir = ($urandom_range(0, 4) == 0);
      s_req   = 1'($urandom);
      s_rdy   = ($urandom_range(0, 9) < 7);
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV64 core (IF/ID/EX/MEM/WB).
- Decides every cycle which pipeline registers advance, which are bubbled, and which PC source IF uses.
- Covers load-use stalls, ID-stage jumps, EX-stage branch redirects and data-memory wait states, with a timeout watchdog and performance counters.
- Sits beside ID; drives the write-enable and flush inputs of all pipeline registers and the PC mux.

Parameters:
- MEM_TIMEOUT, 255: max consecutive MEM_WAIT cycles before HALT (1..2^TO_W-1).
- TO_W, 8: width of the wait-cycle counter.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- id_rs1  in  5  rs1 field of the instruction in ID.
- id_rs2  in  5  rs2 field of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- id_jump  in  1  ID resolved JAL (control_j).
- ex_rd  in  5  destination of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_redirect  in  1  EX resolved taken branch or JALR.
- mem_req  in  1  MEM stage has a data-memory access.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC register enable.
- pc_src  out  2  00 = PC+4, 01 = ID jump target, 10 = EX redirect target.
- ifid_write, idex_write, exmem_write, memwb_write  out  1 each  pipeline register enables.
- ifid_flush, idex_flush  out  1 each  load a bubble (NOP, all ctrl bits 0) into that register.
- mem_timeout  out  1  sticky watchdog flag.
- ctrl_state  out  2  00 = RUN, 01 = MEM_WAIT, 10 = HALT.
- stall_cnt  out  CNT_W  cycles with pc_write = 0.
- flush_cnt  out  CNT_W  flush events.

Behaviour:
- All outputs are combinational from the registered state and the current inputs. Counters and the state are registered.
- Reset (synchronous, active-high): state = RUN, wait counter = 0, mem_timeout = 0, stall_cnt = 0, flush_cnt = 0.
- Outputs during the reset cycle: all enables 0, flushes 0, pc_src = 00.
- Default in RUN: all enables 1, flushes 0, pc_src = 00.

RUN, evaluated in priority order; the first matching condition wins:
1. mem_req & !mem_ready:
   - All four enables 0, pc_write 0, no flush.
   - Next state MEM_WAIT; wait counter = 1.
2. ex_redirect:
   - pc_src = 10, ifid_flush = 1, idex_flush = 1.
   - A load-use condition or id_jump in the same cycle is ignored.
   - flush_cnt += 1.
3. id_jump:
   - pc_src = 01, ifid_flush = 1.
   - Load-use is still checked in the same cycle. If load-use is also true, the stall wins: pc_write = 0, ifid_write = 0, idex_flush = 1, pc_src = 00, no jump flush. The jump re-issues next cycle.
   - flush_cnt += 1 only when the jump is taken.
4. Load-use:
   - Condition: ex_mem_read & ex_rd != 0 & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
   - Action: pc_write = 0, ifid_write = 0, idex_flush = 1. Exactly one bubble per load.

MEM_WAIT:
- While !mem_ready: everything frozen (all enables 0, no flush). Wait counter increments.
- ex_redirect and id_jump are ignored while frozen; they stay asserted because EX and ID are held.
- mem_ready = 1 releases the freeze in that same cycle: the RUN rules apply, excluding rule 1, and next state = RUN.
- If the wait counter reaches MEM_TIMEOUT while still !mem_ready: next state HALT and mem_timeout is set.

HALT:
- All enables 0, flushes 0.
- Left only by reset. mem_timeout stays 1 until reset.

Counters:
- stall_cnt += 1 every non-reset cycle with pc_write = 0.
- Both counters saturate at all-ones; no wrap.
- Reset mid-wait returns to RUN immediately; the wait counter is cleared.

Decomposition:
- Shared package core_pkg holds:
  - The opcode localparams used by ID.
  - The pc_src encodings (PC_SEQ, PC_JUMP, PC_REDIR).
  - The ctrl_state encodings (ST_RUN, ST_MEM_WAIT, ST_HALT).
- One sub-module: hazard_sat_counter (CNT_W parameter, inc, clear); instantiated twice.
- The load-use compare stays inline.

Test Plan:
- Load-use: ex_mem_read = 1, ex_rd = 5, id_rs1 = 5, id_use_rs1 = 1 -> one cycle with pc_write = 0, ifid_write = 0, idex_flush = 1; stall_cnt = 1. With ex_rd = 0 -> no stall.
- Redirect priority: ex_redirect = 1, id_jump = 1, load-use true at once -> pc_src = 10, ifid_flush = 1, idex_flush = 1, pc_write = 1; flush_cnt = 1.
- Jump vs load-use: id_jump = 1 plus load-use -> cycle 1 is a stall with pc_src = 00. Cycle 2 (load now in MEM) gives pc_src = 01, ifid_flush = 1.
- Memory wait: mem_req = 1, mem_ready = 0 for 3 cycles, then 1 -> 3 frozen cycles; ctrl_state = 01 during the wait; release cycle has all enables 1; stall_cnt = 3.
- Timeout: MEM_TIMEOUT = 4, mem_ready held 0 -> ctrl_state = 10 and mem_timeout = 1 after 4 wait cycles. The flag stays set; assert reset -> RUN, mem_timeout = 0.
- Saturation: CNT_W = 3, 10 stall cycles -> stall_cnt = 7 and stays 7.
